pkt_ctrl_mc: RTL and testbench

- Multi-channel successor to the single-pair packet controller.
- Launches up to NUM_CH reader/writer pairs from one request and tracks per-channel read/write completion.
- Returns to idle when every enabled channel has finished. A watchdog timeout aborts a stuck run.
- Exports processing-cycle statistics (last, max, packet count) to the host CSR block.

---
 rtl/pkt_ctrl_mc.sv | 159 +++++++++++++++
 tb/tb_pkt_ctrl_mc.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_ctrl_mc.sv
// pkt_ctrl_mc: launches up to NUM_CH reader/writer channel pairs from a single
// request, tracks per-channel read/write completion, returns to idle once all
// launched channels are finished (or the watchdog aborts the run), and keeps
// processing-cycle statistics for the host.
module pkt_ctrl_mc #(
  parameter int NUM_CH  = 2,
  parameter int CC_W    = 32,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              new_request,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [NUM_CH-1:0] rd_ctrl_rdy,
  input  logic [NUM_CH-1:0] wr_ctrl_rdy,
  input  logic              clr_stats,
  output logic [NUM_CH-1:0] rd_ctrl,
  output logic [NUM_CH-1:0] wr_ctrl,
  output logic [1:0]        state_out,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CC_W-1:0]   processing_cc,
  output logic [CC_W-1:0]   max_cc,
  output logic [CNT_W-1:0]  pkt_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [CC_W-1:0]  CC_MAX  = '1;
  localparam logic [CNT_W-1:0] PKT_MAX = '1;
  localparam bit               WD_EN   = (TIMEOUT != 0);
  localparam logic [CC_W-1:0]  WD_LAST = CC_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] act_mask_q, act_mask_d;
  logic [NUM_CH-1:0] rd_done_q, rd_done_d;
  logic [NUM_CH-1:0] wr_done_q, wr_done_d;
  logic [NUM_CH-1:0] rd_ctrl_q, rd_ctrl_d;
  logic [NUM_CH-1:0] wr_ctrl_q, wr_ctrl_d;
  logic [CC_W-1:0]   cc_ctr_q, cc_ctr_d;
  logic [CC_W-1:0]   processing_cc_q, processing_cc_d;
  logic [CC_W-1:0]   max_cc_q, max_cc_d;
  logic [CNT_W-1:0]  pkt_count_q, pkt_count_d;
  logic              timeout_q, timeout_d;

  logic [NUM_CH-1:0] rd_now, wr_now;
  logic              rd_all, wr_all, wd_fire;

  // Fold this cycle's readies into channel status; a write only counts once its read has completed
  always_comb begin
    rd_now  = rd_done_q | (rd_ctrl_rdy & act_mask_q);
    wr_now  = wr_done_q | (wr_ctrl_rdy & act_mask_q & rd_now);
    rd_all  = (rd_now == act_mask_q);
    wr_all  = (wr_now == act_mask_q);
    wd_fire = WD_EN && (cc_ctr_q == WD_LAST);
  end

  // Next-state and next-value logic for the controller FSM, counters and statistics
  always_comb begin
    state_d         = state_q;
    act_mask_d      = act_mask_q;
    rd_done_d       = rd_done_q;
    wr_done_d       = wr_done_q;
    rd_ctrl_d       = '0;
    wr_ctrl_d       = '0;
    cc_ctr_d        = cc_ctr_q;
    processing_cc_d = processing_cc_q;
    max_cc_d        = max_cc_q;
    pkt_count_d     = pkt_count_q;
    timeout_d       = timeout_q;

    case (state_q)
      IDLE: begin
        if (new_request && (ch_mask != '0)) begin
          state_d    = RUN;
          act_mask_d = ch_mask;
          rd_done_d  = '0;
          wr_done_d  = '0;
          timeout_d  = 1'b0;
          rd_ctrl_d  = ch_mask;
          wr_ctrl_d  = ch_mask;
        end
      end
      RUN, DRAIN: begin
        rd_done_d = rd_now;
        wr_done_d = wr_now;
        if (cc_ctr_q != CC_MAX) cc_ctr_d = cc_ctr_q + 1'b1;
        if (rd_all && wr_all) begin
          state_d = FINISH;
        end else if (wd_fire) begin
          state_d   = FINISH;
          timeout_d = 1'b1;
        end else if (rd_all) begin
          state_d = DRAIN;
        end
      end
      FINISH: begin
        state_d         = IDLE;
        processing_cc_d = cc_ctr_q;
        cc_ctr_d        = '0;
        if (cc_ctr_q > max_cc_q) max_cc_d = cc_ctr_q;
        if (!timeout_q && (pkt_count_q != PKT_MAX)) pkt_count_d = pkt_count_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (clr_stats) begin
      max_cc_d    = '0;
      pkt_count_d = '0;
    end
  end

  // State and output registers, cleared asynchronously so a mid-run reset discards channel status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      act_mask_q      <= '0;
      rd_done_q       <= '0;
      wr_done_q       <= '0;
      rd_ctrl_q       <= '0;
      wr_ctrl_q       <= '0;
      cc_ctr_q        <= '0;
      processing_cc_q <= '0;
      max_cc_q        <= '0;
      pkt_count_q     <= '0;
      timeout_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      act_mask_q      <= act_mask_d;
      rd_done_q       <= rd_done_d;
      wr_done_q       <= wr_done_d;
      rd_ctrl_q       <= rd_ctrl_d;
      wr_ctrl_q       <= wr_ctrl_d;
      cc_ctr_q        <= cc_ctr_d;
      processing_cc_q <= processing_cc_d;
      max_cc_q        <= max_cc_d;
      pkt_count_q     <= pkt_count_d;
      timeout_q       <= timeout_d;
    end
  end

  assign state_out     = state_d;
  assign busy          = (state_q == RUN) || (state_q == DRAIN);
  assign done          = (state_q == IDLE) || (state_q == FINISH);
  assign rd_ctrl       = rd_ctrl_q;
  assign wr_ctrl       = wr_ctrl_q;
  assign timeout       = timeout_q;
  assign processing_cc = processing_cc_q;
  assign max_cc        = max_cc_q;
  assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_pkt_ctrl_mc.sv
// tb_pkt_ctrl_mc: directed and randomized runs of pkt_ctrl_mc. Each run is
// described by per-cycle ready patterns; the expected completion cycles,
// state trace and statistics are worked out from those patterns at run level.
module tb_pkt_ctrl_mc;

  localparam int NCH     = 2;
  localparam int TMO     = 16;
  localparam int NEVER   = 1000;
  localparam int PKT_SAT = 15;

  logic           clk, reset, new_request, clr_stats;
  logic [NCH-1:0] ch_mask, rd_ctrl_rdy, wr_ctrl_rdy, rd_ctrl, wr_ctrl;
  logic [1:0]     state_out;
  logic           busy, done, timeout;
  logic [31:0]    processing_cc, max_cc;
  logic [3:0]     pkt_count;

  int testsRun    = 0;
  int testsFailed = 0;
  int runId       = 0;
  int expProc     = 0;
  int expMax      = 0;
  int expPkt      = 0;

  logic [NCH-1:0] rdPat [1:TMO];
  logic [NCH-1:0] wrPat [1:TMO];

  pkt_ctrl_mc #(
    .NUM_CH (NCH),
    .CC_W   (32),
    .CNT_W  (4),
    .TIMEOUT(TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .new_request  (new_request),
    .ch_mask      (ch_mask),
    .rd_ctrl_rdy  (rd_ctrl_rdy),
    .wr_ctrl_rdy  (wr_ctrl_rdy),
    .clr_stats    (clr_stats),
    .rd_ctrl      (rd_ctrl),
    .wr_ctrl      (wr_ctrl),
    .state_out    (state_out),
    .busy         (busy),
    .done         (done),
    .timeout      (timeout),
    .processing_cc(processing_cc),
    .max_cc       (max_cc),
    .pkt_count    (pkt_count)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something upstream stalls the stimulus
  initial begin
    #1000000;
    $display("[TB] FAIL global_time_limit: simulation still running, required to finish");
    $fatal(1, "[TB] time limit reached");
  end

  // Count one comparison and report it when observed and expected differ
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Quiet all ready patterns before building a new run
  task automatic clearPats();
    for (int c = 1; c <= TMO; c++) begin
      rdPat[c] = '0;
      wrPat[c] = '0;
    end
  endtask

  // Launch one run with the current patterns, predict its outcome and check it cycle by cycle
  task automatic applyStimulus(input logic [NCH-1:0] mask, input bit clrAtFinish, input bit reqAtFinish);
    int rdCyc, wrCyc, rdAll, wrAll, endCyc, expState;
    bit tmo;
    rdAll = 0;
    wrAll = 0;
    for (int i = 0; i < NCH; i++) begin
      if (mask[i]) begin
        rdCyc = NEVER;
        wrCyc = NEVER;
        for (int c = TMO; c >= 1; c--) if (rdPat[c][i]) rdCyc = c;
        for (int c = TMO; c >= 1; c--) if (wrPat[c][i] && c >= rdCyc) wrCyc = c;
        if (rdCyc > rdAll) rdAll = rdCyc;
        if (wrCyc > wrAll) wrAll = wrCyc;
      end
    end
    tmo    = (wrAll > TMO);
    endCyc = tmo ? TMO : wrAll;
    runId++;

    new_request = 1'b1;
    ch_mask     = mask;
    rd_ctrl_rdy = NCH'($urandom);
    wr_ctrl_rdy = NCH'($urandom);
    @(negedge clk);
    checkOutput($sformatf("run%0d_accept_state", runId), state_out, 1);
    @(posedge clk); #1;
    new_request = 1'($urandom_range(0, 1));
    ch_mask     = NCH'($urandom);

    for (int c = 1; c <= endCyc; c++) begin
      rd_ctrl_rdy = rdPat[c];
      wr_ctrl_rdy = wrPat[c];
      if (c == endCyc) expState = 3;
      else if (c >= rdAll) expState = 2;
      else expState = 1;
      @(negedge clk);
      checkOutput($sformatf("run%0d_c%0d_state", runId, c), state_out, expState);
      checkOutput($sformatf("run%0d_c%0d_busy", runId, c), busy, 1);
      checkOutput($sformatf("run%0d_c%0d_rd_ctrl", runId, c), rd_ctrl, (c == 1) ? 64'(mask) : 64'd0);
      checkOutput($sformatf("run%0d_c%0d_wr_ctrl", runId, c), wr_ctrl, (c == 1) ? 64'(mask) : 64'd0);
      if (c == 1) checkOutput($sformatf("run%0d_timeout_cleared", runId), timeout, 0);
      @(posedge clk); #1;
    end

    new_request = reqAtFinish;
    ch_mask     = '1;
    clr_stats   = clrAtFinish;
    rd_ctrl_rdy = NCH'($urandom);
    wr_ctrl_rdy = NCH'($urandom);
    @(negedge clk);
    checkOutput($sformatf("run%0d_fin_state", runId), state_out, 0);
    checkOutput($sformatf("run%0d_fin_done", runId), done, 1);
    checkOutput($sformatf("run%0d_fin_busy", runId), busy, 0);
    checkOutput($sformatf("run%0d_fin_timeout", runId), timeout, 64'(tmo));
    @(posedge clk); #1;
    new_request = 1'b0;
    clr_stats   = 1'b0;
    rd_ctrl_rdy = '0;
    wr_ctrl_rdy = '0;

    expProc = endCyc;
    if (clrAtFinish) begin
      expMax = 0;
      expPkt = 0;
    end else begin
      if (endCyc > expMax) expMax = endCyc;
      if (!tmo && expPkt < PKT_SAT) expPkt++;
    end

    @(negedge clk);
    checkOutput($sformatf("run%0d_idle_state", runId), state_out, 0);
    checkOutput($sformatf("run%0d_idle_rd_ctrl", runId), rd_ctrl, 0);
    checkOutput($sformatf("run%0d_processing_cc", runId), processing_cc, expProc);
    checkOutput($sformatf("run%0d_max_cc", runId), max_cc, expMax);
    checkOutput($sformatf("run%0d_pkt_count", runId), pkt_count, expPkt);
    checkOutput($sformatf("run%0d_idle_timeout", runId), timeout, 64'(tmo));
    @(posedge clk); #1;
  endtask

  // Pulse clr_stats while idle and confirm only max_cc and pkt_count clear
  task automatic clearStats();
    clr_stats = 1'b1;
    @(posedge clk); #1;
    clr_stats = 1'b0;
    expMax = 0;
    expPkt = 0;
    @(negedge clk);
    checkOutput("clr_max_cc", max_cc, 0);
    checkOutput("clr_pkt_count", pkt_count, 0);
    checkOutput("clr_keeps_processing_cc", processing_cc, expProc);
    @(posedge clk); #1;
  endtask

  // A request with an empty mask must be ignored
  task automatic maskZeroRequest();
    new_request = 1'b1;
    ch_mask     = '0;
    rd_ctrl_rdy = NCH'($urandom);
    wr_ctrl_rdy = NCH'($urandom);
    @(negedge clk);
    checkOutput("mask0_req_state", state_out, 0);
    @(posedge clk); #1;
    new_request = 1'b0;
    rd_ctrl_rdy = '0;
    wr_ctrl_rdy = '0;
    @(negedge clk);
    checkOutput("mask0_busy", busy, 0);
    checkOutput("mask0_done", done, 1);
    checkOutput("mask0_rd_ctrl", rd_ctrl, 0);
    checkOutput("mask0_wr_ctrl", wr_ctrl, 0);
    @(posedge clk); #1;
  endtask

  // Main sequence: reset, directed corner cases, saturation, random runs, reset mid-run
  initial begin
    logic [NCH-1:0] mask;
    reset       = 1'b1;
    new_request = 1'b0;
    ch_mask     = '0;
    rd_ctrl_rdy = '0;
    wr_ctrl_rdy = '0;
    clr_stats   = 1'b0;
    clearPats();

    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_state", state_out, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 1);
    checkOutput("reset_rd_ctrl", rd_ctrl, 0);
    checkOutput("reset_wr_ctrl", wr_ctrl, 0);
    checkOutput("reset_timeout", timeout, 0);
    checkOutput("reset_processing_cc", processing_cc, 0);
    checkOutput("reset_max_cc", max_cc, 0);
    checkOutput("reset_pkt_count", pkt_count, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    clearPats();
    rdPat[3] = 2'b01; rdPat[5] = 2'b10; wrPat[8] = 2'b11;
    applyStimulus(2'b11, 1'b0, 1'b0);
    checkOutput("basic_processing_cc", processing_cc, 8);
    checkOutput("basic_pkt_count", pkt_count, 1);

    clearPats();
    rdPat[4] = 2'b01; wrPat[4] = 2'b01;
    applyStimulus(2'b01, 1'b0, 1'b1);
    checkOutput("simul_processing_cc", processing_cc, 4);

    clearPats();
    wrPat[2] = 2'b01; rdPat[5] = 2'b01; wrPat[7] = 2'b01;
    applyStimulus(2'b01, 1'b0, 1'b0);
    checkOutput("early_wr_processing_cc", processing_cc, 7);

    clearPats();
    for (int c = 1; c <= TMO; c++) begin
      rdPat[c] = {1'b0, 1'($urandom_range(0, 1))};
      wrPat[c] = {1'b0, 1'($urandom_range(0, 1))};
    end
    rdPat[4][1] = 1'b1; wrPat[6][1] = 1'b1;
    applyStimulus(2'b10, 1'b0, 1'b0);
    checkOutput("noise_processing_cc", processing_cc, 6);

    maskZeroRequest();

    clearStats();
    clearPats();
    rdPat[10] = 2'b01; wrPat[10] = 2'b01;
    applyStimulus(2'b01, 1'b0, 1'b0);
    clearPats();
    rdPat[6] = 2'b01; wrPat[6] = 2'b01;
    applyStimulus(2'b01, 1'b0, 1'b0);
    checkOutput("two_runs_max_cc", max_cc, 10);
    checkOutput("two_runs_pkt_count", pkt_count, 2);
    clearStats();

    clearPats();
    applyStimulus(2'b11, 1'b0, 1'b0);
    checkOutput("wd_processing_cc", processing_cc, 16);
    checkOutput("wd_pkt_count", pkt_count, 0);
    checkOutput("wd_timeout", timeout, 1);

    clearPats();
    rdPat[3] = 2'b11;
    applyStimulus(2'b11, 1'b0, 1'b0);

    clearPats();
    rdPat[16] = 2'b01; wrPat[16] = 2'b01;
    applyStimulus(2'b01, 1'b0, 1'b0);
    checkOutput("wd_edge_timeout", timeout, 0);
    checkOutput("wd_edge_pkt_count", pkt_count, 1);

    clearPats();
    rdPat[1] = 2'b11; wrPat[1] = 2'b11;
    for (int k = 0; k < 17; k++) applyStimulus(2'b11, 1'b0, 1'b0);
    checkOutput("pkt_count_saturated", pkt_count, PKT_SAT);

    for (int r = 0; r < 40; r++) begin
      mask = NCH'($urandom_range(1, 3));
      for (int c = 1; c <= TMO; c++) begin
        rdPat[c] = {($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0)};
        wrPat[c] = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
      end
      applyStimulus(mask, ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 7) == 0) maskZeroRequest();
      if ($urandom_range(0, 11) == 0) clearStats();
    end

    clearPats();
    rdPat[5] = 2'b01; wrPat[5] = 2'b01;
    applyStimulus(2'b01, 1'b0, 1'b0);
    new_request = 1'b1;
    ch_mask     = 2'b11;
    @(posedge clk); #1;
    new_request = 1'b0;
    rd_ctrl_rdy = 2'b11;
    @(posedge clk); #1;
    rd_ctrl_rdy = 2'b00;
    @(negedge clk);
    checkOutput("rst_pre_drain_state", state_out, 2);
    checkOutput("rst_pre_drain_busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_mid_busy", busy, 0);
    checkOutput("rst_mid_done", done, 1);
    checkOutput("rst_mid_state", state_out, 0);
    checkOutput("rst_mid_rd_ctrl", rd_ctrl, 0);
    checkOutput("rst_mid_wr_ctrl", wr_ctrl, 0);
    checkOutput("rst_mid_timeout", timeout, 0);
    checkOutput("rst_mid_processing_cc", processing_cc, 0);
    checkOutput("rst_mid_max_cc", max_cc, 0);
    checkOutput("rst_mid_pkt_count", pkt_count, 0);
    @(posedge clk); #1;
    reset   = 1'b0;
    expProc = 0;
    expMax  = 0;
    expPkt  = 0;
    @(posedge clk); #1;

    clearPats();
    rdPat[3] = 2'b01; wrPat[3] = 2'b01;
    applyStimulus(2'b01, 1'b0, 1'b0);
    checkOutput("post_reset_pkt_count", pkt_count, 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
